// File: rtl/sync_event_multi_if.sv
// Per-channel event bundle between the async status toggles and the stack control logic.
// master drives the inputs and acks; slave is the synchroniser.
interface sync_event_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] async_in;
    logic [NUM_CH-1:0] event_valid;
    logic [NUM_CH-1:0] event_ack;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] overrun_clr;
    logic [NUM_CH-1:0] sync_level;

    modport master (
        output async_in, event_ack, overrun_clr,
        input  event_valid, overrun, sync_level
    );

    modport slave (
        input  async_in, event_ack, overrun_clr,
        output event_valid, overrun, sync_level
    );
endinterface

// File: rtl/sync_event_multi.sv
// Purpose: multi-channel async-to-clk synchroniser with per-channel edge detect and pulse/held event delivery.
// Latency: an input change captured at edge k shows on event_valid in the cycle after edge k+SYNC_STAGES-1.
// Backpressure: none in pulse mode; held mode keeps the event until acked, merging extra edges into a sticky overrun.
module sync_event_multi #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int HOLD_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_event_multi_if.slave     bus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("sync_event_multi: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] hist_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] ovr_q;
    logic [NUM_CH-1:0] ovr_d;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] det;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= bus.async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= level;
        end
    end

    always_comb begin
        det = level ^ hist_q;
        if (EDGE_MODE == 1) begin
            det = level & ~hist_q;
        end else if (EDGE_MODE == 2) begin
            det = ~level & hist_q;
        end
    end

    // A new edge while one is still unacked merges into the pending one and flags overrun;
    // an ack in the same cycle retires the old event so no overrun is raised.
    always_comb begin
        pend_d = '0;
        ovr_d  = '0;
        if (HOLD_MODE != 0) begin
            pend_d = (det & (pend_q | ~bus.event_ack)) | (~det & pend_q & ~bus.event_ack);
            ovr_d  = (pend_q & det & ~bus.event_ack) | (ovr_q & ~bus.overrun_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.event_valid = pend_q | det;
    assign bus.overrun     = ovr_q;
    assign bus.sync_level  = level;

endmodule

// File: tb/tb_sync_event_multi.sv
// Three configurations of sync_event_multi driven from one shared stimulus and checked
// against an input-history reference model, plus directed scenarios with literal expectations.
module tb_sync_event_multi;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] a_in  = '0;
    logic [3:0] ack   = '0;
    logic [3:0] clr   = '0;
    logic       chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    sync_event_multi_if #(.NUM_CH(4)) if0 ();
    sync_event_multi_if #(.NUM_CH(4)) if1 ();
    sync_event_multi_if #(.NUM_CH(4)) if2 ();

    assign if0.async_in = a_in;  assign if0.event_ack = ack;  assign if0.overrun_clr = clr;
    assign if1.async_in = a_in;  assign if1.event_ack = ack;  assign if1.overrun_clr = clr;
    assign if2.async_in = a_in;  assign if2.event_ack = ack;  assign if2.overrun_clr = clr;

    sync_event_multi #(.NUM_CH(4), .SYNC_STAGES(2), .EDGE_MODE(0), .HOLD_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    sync_event_multi #(.NUM_CH(4), .SYNC_STAGES(3), .EDGE_MODE(1), .HOLD_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    sync_event_multi #(.NUM_CH(4), .SYNC_STAGES(2), .EDGE_MODE(2), .HOLD_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2));

    int ss_a [3] = '{2, 3, 2};
    int em_a [3] = '{0, 1, 2};
    int hm_a [3] = '{0, 1, 1};

    // Reference model: q holds the input seen at each clock edge since the last reset,
    // newest last. The synchronised level is the sample taken SYNC_STAGES-1 edges ago.
    logic [3:0] q [$];
    logic [3:0] mp [3] = '{4'h0, 4'h0, 4'h0};
    logic [3:0] mo [3] = '{4'h0, 4'h0, 4'h0};

    function automatic logic [3:0] sample(int age);
        if (age < q.size()) return q[q.size() - 1 - age];
        return 4'h0;
    endfunction

    function automatic logic [3:0] mdet(int i);
        logic [3:0] lv;
        logic [3:0] pv;
        lv = sample(ss_a[i] - 1);
        pv = sample(ss_a[i]);
        if (em_a[i] == 1) return lv & ~pv;
        if (em_a[i] == 2) return ~lv & pv;
        return lv ^ pv;
    endfunction

    // Count outstanding events per channel: pending plus new edge, minus one if acked.
    function automatic int outstanding(int i, int c);
        int n;
        logic [3:0] d;
        d = mdet(i);
        n = (mp[i][c] ? 1 : 0) + (d[c] ? 1 : 0);
        if (ack[c] && n > 0) n = n - 1;
        return n;
    endfunction

    function automatic logic [3:0] mnext_p(int i);
        logic [3:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c] = (outstanding(i, c) > 0);
        if (hm_a[i] == 0) r = '0;
        return r;
    endfunction

    function automatic logic [3:0] mnext_o(int i);
        logic [3:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c] = (outstanding(i, c) > 1) || (mo[i][c] && !clr[c]);
        if (hm_a[i] == 0) r = '0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 3; i++) begin
                mp[i] <= '0;
                mo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mp[i] <= mnext_p(i);
                mo[i] <= mnext_o(i);
            end
            q.push_back(a_in);
            if (q.size() > 16) void'(q.pop_front());
        end
    end

    task automatic check(string nm, int inst, logic [3:0] got, logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %b, expected %b at %0t", nm, inst, got, exp, $time);
        end
    endtask

    task automatic cmp(int i, logic [3:0] ev, logic [3:0] ov, logic [3:0] sl);
        logic [3:0] e_ev;
        logic [3:0] e_ov;
        logic [3:0] e_sl;
        e_ev = '0;
        e_ov = '0;
        e_sl = '0;
        if (rst_n) begin
            e_ev = (hm_a[i] != 0) ? (mp[i] | mdet(i)) : mdet(i);
            e_ov = mo[i];
            e_sl = sample(ss_a[i] - 1);
        end
        check("model_event_valid", i, ev, e_ev);
        check("model_overrun", i, ov, e_ov);
        check("model_sync_level", i, sl, e_sl);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, if0.event_valid, if0.overrun, if0.sync_level);
            cmp(1, if1.event_valid, if1.overrun, if1.sync_level);
            cmp(2, if2.event_valid, if2.overrun, if2.sync_level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int age [4] = '{0, 0, 0, 0};

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_ev", 0, if0.event_valid, 4'b0000);
        check("reset_ev", 1, if1.event_valid, 4'b0000);
        check("reset_ov", 1, if1.overrun, 4'b0000);
        check("reset_sl", 1, if1.sync_level, 4'b0000);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // ch0 rise: 2-stage any-edge pulse, then 3-stage rising held event
        tick();
        a_in[0] = 1'b1;
        @(negedge clk); check("lat_early0", 0, if0.event_valid, 4'b0000);
        tick(); @(negedge clk); check("lat_early1", 0, if0.event_valid, 4'b0000);
        tick(); @(negedge clk);
        check("lat_pulse", 0, if0.event_valid, 4'b0001);
        check("lat_hold_early", 1, if1.event_valid, 4'b0000);
        tick(); @(negedge clk);
        check("pulse_one_cycle", 0, if0.event_valid, 4'b0000);
        check("lat_hold", 1, if1.event_valid, 4'b0001);
        repeat (20) tick();
        @(negedge clk);
        check("held_20", 1, if1.event_valid, 4'b0001);
        check("held_no_ovr", 1, if1.overrun, 4'b0000);
        tick(); ack = 4'b0001;
        tick(); ack = 4'b0000;
        @(negedge clk);
        check("acked", 1, if1.event_valid, 4'b0000);
        check("acked_ovr", 1, if1.overrun, 4'b0000);

        // ch1: two rises unacked -> overrun; clr colliding with a new det keeps it
        tick(); a_in[1] = 1'b1;
        repeat (4) tick(); a_in[1] = 1'b0;
        repeat (4) tick(); a_in[1] = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("merge_ev", 1, if1.event_valid, 4'b0010);
        check("merge_ovr", 1, if1.overrun, 4'b0010);
        check("fall_single_ev", 2, if2.event_valid, 4'b0010);
        check("fall_single_ovr", 2, if2.overrun, 4'b0000);
        tick(); a_in[1] = 1'b0;
        repeat (4) tick(); a_in[1] = 1'b1;
        repeat (3) tick(); clr = 4'b0010;
        tick(); clr = 4'b0000;
        @(negedge clk);
        check("set_beats_clr", 1, if1.overrun, 4'b0010);
        check("set_beats_clr_ev", 1, if1.event_valid, 4'b0010);
        tick(); clr = 4'b0010;
        tick(); clr = 4'b0000;
        @(negedge clk);
        check("clr_alone", 1, if1.overrun, 4'b0000);
        check("clr_keeps_ev", 1, if1.event_valid, 4'b0010);
        tick(); ack = 4'b1111;
        tick(); ack = 4'b0000;
        @(negedge clk);
        check("drain", 1, if1.event_valid, 4'b0000);
        check("drain", 2, if2.event_valid, 4'b0000);

        // ch3: ack lands on the same cycle as a new det
        tick(); a_in[3] = 1'b1;
        repeat (4) tick(); a_in[3] = 1'b0;
        repeat (4) tick(); a_in[3] = 1'b1;
        repeat (3) tick(); ack = 4'b1000;
        tick(); ack = 4'b0000;
        @(negedge clk);
        check("ack_with_det_ev", 1, if1.event_valid, 4'b1000);
        check("ack_with_det_ovr", 1, if1.overrun, 4'b0000);
        tick(); ack = 4'b1000;
        tick(); ack = 4'b0000;
        @(negedge clk);
        check("second_ack", 1, if1.event_valid, 4'b0000);

        // ch2: 8-cycle high pulse; falling-edge instance fires only on the fall
        tick(); a_in[2] = 1'b1;
        repeat (2) tick(); @(negedge clk);
        check("rise_any", 0, if0.event_valid, 4'b0100);
        check("rise_ignored", 2, if2.event_valid, 4'b0000);
        repeat (6) tick(); a_in[2] = 1'b0;
        repeat (2) tick(); @(negedge clk);
        check("fall_any", 0, if0.event_valid, 4'b0100);
        check("fall_event", 2, if2.event_valid, 4'b0100);
        tick(); ack = 4'b1111;
        tick(); ack = 4'b0000;

        // all-ones through a mid-pending reset
        tick(); a_in = 4'b1111;
        repeat (5) tick(); @(negedge clk);
        check("pending_before_rst", 1, if1.event_valid, 4'b0100);
        tick(); rst_n = 1'b0;
        #1;
        check("rst_now_ev", 1, if1.event_valid, 4'b0000);
        check("rst_now_ev", 2, if2.event_valid, 4'b0000);
        check("rst_now_sl", 0, if0.sync_level, 4'b0000);
        repeat (3) tick(); rst_n = 1'b1;
        repeat (2) tick(); @(negedge clk);
        check("post_rst_early", 1, if1.event_valid, 4'b0000);
        tick(); @(negedge clk);
        check("post_rst_rise", 1, if1.event_valid, 4'b1111);
        check("post_rst_nofall", 2, if2.event_valid, 4'b0000);
        tick(); ack = 4'b1111;
        tick(); ack = 4'b0000;

        // randomized phase, respecting the minimum hold time per level
        for (int n = 0; n < 800; n++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                age[c]++;
                if (age[c] >= 4 && $urandom_range(0, 3) == 0) begin
                    a_in[c] = ~a_in[c];
                    age[c] = 0;
                end
            end
            ack = 4'($urandom & $urandom);
            clr = 4'($urandom & $urandom & $urandom);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
        end
        tick();
        rst_n = 1'b1;
        ack = 4'b0000;
        clr = 4'b0000;
        repeat (6) tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
